// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch top level and its next-PC mux.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_REG = 2'b10;
    localparam logic [1:0] PCS_JMP = 2'b11;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: live decode redirect, then a parked redirect,
// then the sequential PC+4.
module next_pc_mux
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcsource,
    input  logic        id_valid,
    input  logic        redir_v,
    input  logic [31:0] redir_pc,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] target,
    output logic [31:0] npc
);

    always_comb begin
        target = bpc;
        unique case (pcsource)
            PCS_REG: target = rpc;
            PCS_JMP: target = jpc;
            default: target = bpc;
        endcase
    end

    always_comb begin
        npc = pc + 32'd4;
        if (id_valid && pcsource != PCS_SEQ) begin
            npc = target;
        end else if (redir_v) begin
            npc = redir_pc;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage: one outstanding imem request, skid buffer for responses
// that land during a load-use stall, IF/ID register with bubbles.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_q;
    logic [31:0] skid_q;
    logic        redir_v_q;
    logic [31:0] redir_pc_q;
    logic [31:0] npc;
    logic [31:0] target;
    logic [31:0] deliver_word;
    logic        deliver;
    logic        skid_load;

    next_pc_mux u_next_pc_mux (
        .pc       (pc_q),
        .pcsource (pcsource),
        .id_valid (id_valid),
        .redir_v  (redir_v_q),
        .redir_pc (redir_pc_q),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .target   (target),
        .npc      (npc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall never blocks the memory side, only delivery into ID.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:   if (imem_gnt) state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_d = stall ? S_HOLD : S_REQ;
            S_HOLD:  if (!stall) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        imem_req     = resetn && (state_q == S_REQ);
        imem_addr    = pc_q;
        deliver      = !stall && ((state_q == S_WAIT && imem_rvalid)
                                  || state_q == S_HOLD);
        skid_load    = stall && state_q == S_WAIT && imem_rvalid;
        deliver_word = (state_q == S_HOLD) ? skid_q : imem_rdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= RESET_PC;
            skid_q     <= 32'h0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= 32'h0;
            id_inst    <= NOP_INST;
            id_pc4     <= 32'h0;
            id_valid   <= 1'b0;
        end else begin
            if (skid_load) begin
                skid_q <= imem_rdata;
            end
            if (deliver) begin
                id_inst   <= deliver_word;
                id_pc4    <= pc_q + 32'd4;
                id_valid  <= 1'b1;
                pc_q      <= npc;
                redir_v_q <= 1'b0;
            end else if (!stall) begin
                id_inst  <= NOP_INST;
                id_valid <= 1'b0;
                // Branch leaves ID before its delay slot: park the target.
                if (id_valid && pcsource != PCS_SEQ) begin
                    redir_v_q  <= 1'b1;
                    redir_pc_q <= target;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit with a response scoreboard.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] jpc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;
    exp_t exp_q[$];

    inst_fetch_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .stall       (stall),
        .pcsource    (pcsource),
        .bpc         (bpc),
        .rpc         (rpc),
        .jpc         (jpc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_inst     (id_inst),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory answers in WAIT; the expected IF/ID contents are queued.
    task automatic respond(input logic [31:0] word, input logic [31:0] pc4);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        exp_q.push_back('{word, pc4});
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() == 0) e = '{32'hDEAD_BEEF, 32'hDEAD_BEEF};
        else e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc();
        cyc();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL rst_inst: got %h want 0", id_inst); end
        checks++; if (imem_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL rst_pc: got %h want bfc00000", imem_addr); end
        resetn = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL first_addr: got %h want bfc00000", imem_addr); end
    endtask

    task automatic test_sequential();
        exp_t e;
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL seq_wait_req: got %b want 0", imem_req); end
        respond(32'h2402_0001, 32'hBFC0_0004);
        pop_exp(e);
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL seq_valid: got %b want 1", id_valid); end
        checks++; if (id_inst !== e.inst) begin failures++; $display("FAIL seq_inst: got %h want %h", id_inst, e.inst); end
        checks++; if (id_pc4 !== e.pc4) begin failures++; $display("FAIL seq_pc4: got %h want %h", id_pc4, e.pc4); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL seq_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'hBFC0_0004) begin failures++; $display("FAIL seq_addr: got %h want bfc00004", imem_addr); end
    endtask

    task automatic test_delay_slot();
        exp_t e;
        pcsource = 2'b01;
        bpc      = 32'hBFC0_0100;
        imem_gnt = 1'b1;
        cyc();
        pcsource = 2'b00;
        imem_gnt = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL ds_bubble: got %b want 0", id_valid); end
        respond(32'h0085_1020, 32'hBFC0_0008);
        pop_exp(e);
        checks++; if (id_inst !== e.inst) begin failures++; $display("FAIL ds_inst: got %h want %h", id_inst, e.inst); end
        checks++; if (id_pc4 !== e.pc4) begin failures++; $display("FAIL ds_pc4: got %h want %h", id_pc4, e.pc4); end
        checks++; if (imem_addr !== 32'hBFC0_0100) begin failures++; $display("FAIL ds_target: got %h want bfc00100", imem_addr); end
    endtask

    task automatic test_stall();
        exp_t e;
        stall    = 1'b1;
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL st_wait: got %b want 0", imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8C43_0000;
        exp_q.push_back('{32'h8C43_0000, 32'hBFC0_0104});
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL st_hold_req[%0d]: got %b want 0", i, imem_req); end
            checks++; if (id_inst !== 32'h0085_1020) begin failures++; $display("FAIL st_frozen[%0d]: got %h want 00851020", i, id_inst); end
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL st_valid[%0d]: got %b want 1", i, id_valid); end
            cyc();
        end
        stall    = 1'b0;
        pcsource = 2'b11;
        jpc      = 32'h0040_0000;
        cyc();
        pcsource = 2'b00;
        pop_exp(e);
        checks++; if (id_inst !== e.inst) begin failures++; $display("FAIL st_inst: got %h want %h", id_inst, e.inst); end
        checks++; if (id_pc4 !== e.pc4) begin failures++; $display("FAIL st_pc4: got %h want %h", id_pc4, e.pc4); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL st_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL st_jump: got %h want 00400000", imem_addr); end
    endtask

    task automatic test_slow_redirect();
        exp_t e;
        pcsource = 2'b10;
        rpc      = 32'h8000_1000;
        cyc();
        pcsource = 2'b00;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL sr_bubble: got %b want 0", id_valid); end
        checks++; if (id_pc4 !== 32'hBFC0_0104) begin failures++; $display("FAIL sr_pc4_kept: got %h want bfc00104", id_pc4); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL sr_addr_stable[%0d]: got %h want 00400000", i, imem_addr); end
            cyc();
        end
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        respond(32'h2442_0004, 32'h0040_0004);
        pop_exp(e);
        checks++; if (id_inst !== e.inst) begin failures++; $display("FAIL sr_inst: got %h want %h", id_inst, e.inst); end
        checks++; if (id_pc4 !== e.pc4) begin failures++; $display("FAIL sr_pc4: got %h want %h", id_pc4, e.pc4); end
        checks++; if (imem_addr !== 32'h8000_1000) begin failures++; $display("FAIL sr_target: got %h want 80001000", imem_addr); end
    endtask

    task automatic test_wrap();
        exp_t e;
        pcsource = 2'b11;
        jpc      = 32'hFFFF_FFFC;
        imem_gnt = 1'b1;
        cyc();
        pcsource = 2'b00;
        imem_gnt = 1'b0;
        respond(32'h1111_1111, 32'h8000_1004);
        pop_exp(e);
        checks++; if (id_inst !== e.inst) begin failures++; $display("FAIL wr_inst0: got %h want %h", id_inst, e.inst); end
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_addr0: got %h want fffffffc", imem_addr); end
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        respond(32'h2222_2222, 32'h0000_0000);
        pop_exp(e);
        checks++; if (id_pc4 !== e.pc4) begin failures++; $display("FAIL wr_pc4: got %h want %h", id_pc4, e.pc4); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wr_addr1: got %h want 00000000", imem_addr); end
    endtask

    task automatic test_rvalid_in_req();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rq_state: got %b want 1", imem_req); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rq_valid: got %b want 0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL rq_inst: got %h want 0", id_inst); end
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        resetn = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rw_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL rw_pc: got %h want bfc00000", imem_addr); end
        checks++; if (id_pc4 !== 32'h0) begin failures++; $display("FAIL rw_pc4: got %h want 0", id_pc4); end
        cyc();
        resetn = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rw_first_req: got %b want 1", imem_req); end
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        respond(32'h3C1D_8000, 32'hBFC0_0004);
        pop_exp(e);
        checks++; if (id_inst !== e.inst) begin failures++; $display("FAIL rw_inst: got %h want %h", id_inst, e.inst); end
        checks++; if (id_pc4 !== e.pc4) begin failures++; $display("FAIL rw_pc4_after: got %h want %h", id_pc4, e.pc4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delay_slot();
        test_stall();
        test_slow_redirect();
        test_wrap();
        test_rvalid_in_req();
        test_reset_in_wait();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch stage for the five-stage MIPS pipeline. It holds the PC, issues one word request at a time to instruction memory over a request/grant/response handshake, and loads the IF/ID pipeline register. Its next PC comes from the decode stage's `pcsource` selection and branch/jump targets, and it honours the decode-stage load-use stall. Branches and jumps resolve in ID with one architectural delay slot and no flush.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC value after reset.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode-stage load-use stall, high = hold. While high, IF/ID, PC and the redirect register are frozen.
- `pcsource`  in  2  next-PC select from decode for the instruction in ID:
  - 00: sequential.
  - 01: branch target.
  - 10: register target (jr/jalr).
  - 11: jump target (j/jal).
- `bpc`  in  32  branch target.
- `rpc`  in  32  register target.
- `jpc`  in  32  jump target.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  word address, equal to PC, stable while `imem_req` is high.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid, one cycle, at least one cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `id_inst`  out  32  IF/ID instruction. A bubble is 32'h0.
- `id_pc4`  out  32  IF/ID PC+4.
- `id_valid`  out  1  IF/ID holds a real instruction.

## Operation
- FSM states: REQ, WAIT, HOLD. A 32-bit skid buffer holds a response that arrives while stalled.
  - REQ: drive `imem_req`=1 and `imem_addr`=PC. On `imem_gnt`, go to WAIT.
  - WAIT: wait for `imem_rvalid`.
    - If `imem_rvalid` and not `stall`: deliver `imem_rdata`, then go to REQ.
    - If `imem_rvalid` and `stall`: capture `imem_rdata` in the skid buffer, then go to HOLD.
  - HOLD: when `stall` is low, deliver the skid buffer, then go to REQ.
- At most one request is outstanding; the block never issues a new request before the response.
- Deliver (same edge):
  - `id_inst` ← word.
  - `id_pc4` ← PC+4.
  - `id_valid` ← 1.
  - PC ← npc.
  - redirect register cleared.
- When not stalled and nothing is delivered, IF/ID loads a bubble: inst 0, `id_valid` 0, `id_pc4` unchanged. PC is unchanged.
- Target selection: `target` = `bpc` / `rpc` / `jpc` for `pcsource` = 01 / 10 / 11.
- Redirect capture: when not stalled, `id_valid`=1 and `pcsource`≠00:
  - If no delivery happens this cycle, set `redir_v`=1 and `redir_pc`=`target`.
  - This keeps the target of a branch that leaves ID before its delay slot arrives.
- npc priority:
  1. `id_valid`=1 and `pcsource`≠00: `target`.
  2. `redir_v`=1: `redir_pc`.
  3. Otherwise: PC+4.
- `pcsource` is ignored when `id_valid`=0.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] pass through unchecked.
- Stall only freezes the ID side. REQ→WAIT and WAIT→HOLD still progress.

## Timing
- Reset values:
  - PC = `RESET_PC`.
  - State = REQ.
  - `imem_req` = 0 while `resetn` is low.
  - `id_inst` = 0, `id_pc4` = 0, `id_valid` = 0.
  - `redir_v` = 0, skid buffer = 0.
- The first request is asserted in the first cycle with `resetn` high.
- Best-case throughput is one instruction per 2 cycles: grant in the request cycle, `imem_rvalid` the next cycle, then a new REQ.
- Delivery latency: the instruction is visible at `id_inst` in the cycle after `imem_rvalid` (no stall).
- Reset asserted mid-WAIT or mid-HOLD abandons the transfer. Instruction memory shares `resetn`, so no stale `imem_rvalid` arrives after reset.
- An `imem_rvalid` seen in REQ is a protocol error and is ignored.
- Simultaneous `stall` rise and `imem_rvalid`: the response goes to the skid buffer and IF/ID is unchanged.

## Structure
- Shared package `fetch_pkg`:
  - State enum.
  - `pcsource` encodings PCS_SEQ, PCS_BR, PCS_REG, PCS_JMP.
  - `NOP_INST` = 32'h0.
  - `RESET_PC` default.
- One combinational sub-module, `next_pc_mux`: PC, `pcsource`, `id_valid`, `redir_v`, `redir_pc`, `bpc`, `rpc`, `jpc` in; npc out.

## Test plan
- Reset: `resetn` low → `imem_req`=0, `id_valid`=0, PC=BFC00000. Release → `imem_req`=1, `imem_addr`=BFC00000 in the first cycle.
- Sequential: immediate grant, `imem_rvalid` next cycle with 24020001 → `id_inst`=24020001, `id_pc4`=BFC00004, next `imem_addr`=BFC00004.
- Delay slot: ID holds beq with `pcsource`=01, `bpc`=BFC00100, and the delay slot at BFC00004 is delivered → next `imem_addr`=BFC00100.
- Stall: `stall`=1 when `imem_rvalid` arrives with 8C430000 → HOLD, IF/ID unchanged, no request. `stall` low 3 cycles later → `id_inst`=8C430000, then REQ.
- Slow memory redirect: jr with `pcsource`=10, `rpc`=80001000 leaves ID while the delay-slot grant is delayed 4 cycles → bubble (`id_valid`=0). After the delay slot is delivered → `imem_addr`=80001000.
- Reset in WAIT → all outputs return to reset values immediately; first post-reset `imem_addr`=BFC00000.
